framebuffer_writer: RTL and testbench

Pixel sink for `TriRasterEngine`. It accepts the engine's unthrottled pixel-write stream (`o_write_pixel`, `o_x`, `o_y`, `o_color_*`) and clips each pixel to the framebuffer. It packs the colour to RGB565, computes the linear framebuffer address and buffers the result in a FIFO. It then drains that FIFO to the memory write port over a req/ack handshake, and reports overflow, clipping and end-of-draw flush completion.

---
 rtl/framebuffer_writer.sv | 188 ++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_writer
// Purpose  : Clips the raster pixel stream to the framebuffer, packs colour to
//            RGB565, computes word addresses, buffers writes in a FIFO and
//            drains them over a req/ack memory port with flush detection.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_writer #(
  parameter int FB_WIDTH     = 320,
  parameter int FB_HEIGHT    = 240,
  parameter int FB_BASE      = 0,
  parameter int ADDR_BITS    = 18,
  parameter int FIFO_DEPTH   = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_write_pixel,
  input  logic signed [15:0]            i_x,
  input  logic signed [15:0]            i_y,
  input  logic [7:0]                    i_color_r,
  input  logic [7:0]                    i_color_g,
  input  logic [7:0]                    i_color_b,
  input  logic                          i_raster_done,
  input  logic                          i_clear_status,
  output logic                          o_mem_req,
  output logic [ADDR_BITS-1:0]          o_mem_addr,
  output logic [15:0]                   o_mem_data,
  input  logic                          i_mem_ack,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic [15:0]                   o_clip_count,
  output logic                          o_idle,
  output logic                          o_flush_done
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_ent_w = ADDR_BITS + 16;
  localparam int c_cnt_w = $clog2(DRAIN_CYCLES + 1);
  localparam logic [16:0] c_fb_w = 17'(FB_WIDTH);
  localparam logic [16:0] c_fb_h = 17'(FB_HEIGHT);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_REQ} state_t;

  state_t               state_q, state_d;
  logic                 s1_valid_q;
  logic [15:0]          s1_x_q, s1_y_q, s1_data_q;
  logic [c_ptr_w:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [c_ent_w-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [15:0]          mem_data_q;
  logic [15:0]          clip_q;
  logic                 overflow_q, idle_q, idle_d, flush_q, flush_d;
  logic                 armed_q, armed_d;
  logic [c_cnt_w-1:0]   drain_q, drain_d;

  logic                 w_in_bounds, w_accept, w_clip;
  logic [ADDR_BITS-1:0] w_s2_addr;
  logic [c_ptr_w:0]     w_level;
  logic                 w_empty, w_full, w_push, w_pop, w_drop;
  logic [c_ent_w-1:0]   w_head;

  // Coordinates are signed; the sign bit rejects negatives before the
  // zero-extended upper-bound compare.
  assign w_in_bounds = ~i_x[15] & ~i_y[15] &
                       ({1'b0, i_x} < c_fb_w) & ({1'b0, i_y} < c_fb_h);
  assign w_accept    = i_write_pixel & w_in_bounds;
  assign w_clip      = i_write_pixel & ~w_in_bounds;

  // Stage 2 is the address computation feeding the FIFO push directly.
  assign w_s2_addr = ADDR_BITS'(FB_BASE) + ADDR_BITS'(s1_y_q) * ADDR_BITS'(FB_WIDTH)
                   + ADDR_BITS'(s1_x_q);

  assign w_level = wr_ptr_q - rd_ptr_q;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == c_depth);
  assign w_head  = fifo_mem[rd_ptr_q[c_ptr_w-1:0]];
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push  = s1_valid_q & (~w_full | w_pop);
  assign w_drop  = s1_valid_q & w_full & ~w_pop;
  assign wr_ptr_d = wr_ptr_q + {{c_ptr_w{1'b0}}, w_push};
  assign rd_ptr_d = rd_ptr_q + {{c_ptr_w{1'b0}}, w_pop};

  // Memory-port FSM: next state and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          if (!w_empty) w_pop = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle looks ahead at post-edge state so the register reflects it directly.
  assign idle_d = ~w_accept & (wr_ptr_d == rd_ptr_d) & (state_d == ST_IDLE);

  // Flush detection: count quiet idle cycles while armed.
  always_comb begin
    armed_d = armed_q | i_raster_done;
    drain_d = '0;
    flush_d = 1'b0;
    if (armed_q && idle_q && !i_write_pixel) begin
      if (drain_q == c_drain_last) begin
        flush_d = 1'b1;
        armed_d = i_raster_done;
      end else begin
        drain_d = drain_q + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) fifo_mem[wr_ptr_q[c_ptr_w-1:0]] <= {w_s2_addr, s1_data_q};
  end

  // Pipeline, FIFO pointers, output register and FSM state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= w_accept;
      if (w_accept) begin
        s1_x_q    <= i_x;
        s1_y_q    <= i_y;
        s1_data_q <= {i_color_r[7:3], i_color_g[7:2], i_color_b[7:3]};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_pop) {mem_addr_q, mem_data_q} <= w_head;
      idle_q <= idle_d;
    end
  end

  // Status and flush registers; a clear beats a same-edge clip or overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      clip_q     <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      drain_q    <= '0;
      flush_q    <= 1'b0;
    end else begin
      if (i_clear_status)                   clip_q <= '0;
      else if (w_clip && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
      if (i_clear_status)  overflow_q <= 1'b0;
      else if (w_drop)     overflow_q <= 1'b1;
      armed_q <= armed_d;
      drain_q <= drain_d;
      flush_q <= flush_d;
    end
  end

  assign o_mem_req    = (state_q == ST_REQ);
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_level      = w_level;
  assign o_overflow   = overflow_q;
  assign o_clip_count = clip_q;
  assign o_idle       = idle_q;
  assign o_flush_done = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_writer
// Purpose  : Directed self-checking bench for framebuffer_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_writer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               write_pixel;
  logic signed [15:0] px_x, px_y;
  logic [7:0]         col_r, col_g, col_b;
  logic               raster_done, clear_status, mem_ack;
  logic               mem_req;
  logic [17:0]        mem_addr;
  logic [15:0]        mem_data;
  logic [4:0]         level;
  logic               overflow, idle, flush_done;
  logic [15:0]        clip_count;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int last_ack_cyc = -1;
  int flush_cyc = -1;
  int flush_cnt = 0;
  logic [33:0] wq[$];
  int wcyc[$];

  always #5 clk = ~clk;

  framebuffer_writer dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_write_pixel  (write_pixel),
    .i_x            (px_x),
    .i_y            (px_y),
    .i_color_r      (col_r),
    .i_color_g      (col_g),
    .i_color_b      (col_b),
    .i_raster_done  (raster_done),
    .i_clear_status (clear_status),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .o_mem_data     (mem_data),
    .i_mem_ack      (mem_ack),
    .o_level        (level),
    .o_overflow     (overflow),
    .o_clip_count   (clip_count),
    .o_idle         (idle),
    .o_flush_done   (flush_done)
  );

  // Record every accepted write and every flush pulse with its edge index.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_ack) begin
      wq.push_back({mem_addr, mem_data});
      wcyc.push_back(cyc);
      last_ack_cyc = cyc;
    end
    if (flush_done) begin
      flush_cnt = flush_cnt + 1;
      flush_cyc = cyc - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_px(input int x, input int y, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
    write_pixel = 1'b1;
    px_x = 16'(x);
    px_y = 16'(y);
    col_r = r; col_g = g; col_b = b;
    tick();
    write_pixel = 1'b0;
  endtask

  initial begin
    logic [15:0] p_addr_data;
    logic [17:0] p_addr;
    logic        p_req, p_ack;

    reset_n = 1'b0; write_pixel = 1'b0; px_x = '0; px_y = '0;
    col_r = '0; col_g = '0; col_b = '0;
    raster_done = 1'b0; clear_status = 1'b0; mem_ack = 1'b0;
    tick(3);
    check("rst_req", 32'(mem_req), 0);
    check("rst_level", 32'(level), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_clip", 32'(clip_count), 0);
    check("rst_flush", 32'(flush_done), 0);
    reset_n = 1'b1;
    tick(2);

    // Single pixel: three edges from input to request.
    mem_ack = 1'b1;
    wq.delete(); wcyc.delete();
    drive_px(10, 5, 8'd255, 8'd0, 8'd0);
    check("sp_req_n0", 32'(mem_req), 0);
    tick();
    check("sp_req_n1", 32'(mem_req), 0);
    check("sp_level_n1", 32'(level), 1);
    tick();
    check("sp_req_n2", 32'(mem_req), 1);
    check("sp_addr", 32'(mem_addr), 1610);
    check("sp_data", 32'(mem_data), 32'h0000F800);
    tick();
    check("sp_req_n3", 32'(mem_req), 0);
    check("sp_idle", 32'(idle), 1);
    check("sp_writes", 32'(wq.size()), 1);

    // Clipping on every edge of the window.
    wq.delete(); wcyc.delete();
    drive_px(320, 0, 8'hFF, 8'hFF, 8'hFF);
    drive_px(-1, 4, 8'hFF, 8'hFF, 8'hFF);
    drive_px(0, 240, 8'hFF, 8'hFF, 8'hFF);
    drive_px(319, 239, 8'hFF, 8'hFF, 8'hFF);
    tick(6);
    check("clip_writes", 32'(wq.size()), 1);
    if (wq.size() > 0) begin
      check("clip_addr", 32'(wq[0][33:16]), 76799);
      check("clip_data", 32'(wq[0][15:0]), 32'h0000FFFF);
    end
    check("clip_count", 32'(clip_count), 3);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("clip_cleared", 32'(clip_count), 0);

    // Overflow: 20 pixels against a stalled port.
    mem_ack = 1'b0;
    wq.delete(); wcyc.delete();
    for (int i = 0; i < 20; i++) drive_px(i, 0, 8'(i * 8), 8'd0, 8'd0);
    tick(3);
    check("ovf_level", 32'(level), 16);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    tick(20);
    check("ovf_writes", 32'(wq.size()), 17);
    for (int i = 0; i < 17 && i < wq.size(); i++) begin
      check($sformatf("ovf_addr%0d", i), 32'(wq[i][33:16]), 32'(i));
      check($sformatf("ovf_data%0d", i), 32'(wq[i][15:0]),
            32'(rgb565(8'(i * 8), 8'd0, 8'd0)));
      if (i > 0) check($sformatf("ovf_gap%0d", i), 32'(wcyc[i] - wcyc[i-1]), 1);
    end
    check("ovf_level_end", 32'(level), 0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Handshake stall: ack only on every third cycle.
    mem_ack = 1'b0;
    wq.delete(); wcyc.delete();
    for (int i = 0; i < 3; i++) drive_px(100 + i, 7, 8'(i * 40), 8'hA4, 8'h38);
    for (int k = 0; k < 30; k++) begin
      mem_ack = (k % 3 == 2);
      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_addr_data = mem_data;
      tick();
      if (p_req && !p_ack) begin
        check("stall_req", 32'(mem_req), 1);
        check("stall_addr", 32'(mem_addr), 32'(p_addr));
        check("stall_data", 32'(mem_data), 32'(p_addr_data));
      end
    end
    check("stall_writes", 32'(wq.size()), 3);
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      check($sformatf("stall_addr%0d", i), 32'(wq[i][33:16]), 32'(7 * 320 + 100 + i));
      check($sformatf("stall_data%0d", i), 32'(wq[i][15:0]),
            32'(rgb565(8'(i * 40), 8'hA4, 8'h38)));
    end

    // Flush after a drawn burst.
    mem_ack = 1'b1;
    wq.delete(); wcyc.delete();
    flush_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      raster_done = (i == 2);
      drive_px(i, 1, 8'h10, 8'h20, 8'h30);
    end
    raster_done = 1'b0;
    tick(20);
    check("flush_writes", 32'(wq.size()), 5);
    check("flush_count", 32'(flush_cnt), 1);
    check("flush_delay", 32'(flush_cyc - last_ack_cyc), 8);

    // A pixel arriving mid-count restarts the drain count.
    flush_cnt = 0;
    raster_done = 1'b1;
    tick();
    raster_done = 1'b0;
    tick(4);
    drive_px(50, 2, 8'h00, 8'h00, 8'hFF);
    tick(20);
    check("restart_count", 32'(flush_cnt), 1);
    check("restart_delay", 32'(flush_cyc - last_ack_cyc), 8);

    // Asynchronous reset with a request outstanding.
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) drive_px(i, 3, 8'hFF, 8'hFF, 8'hFF);
    tick(3);
    check("rb_req", 32'(mem_req), 1);
    check("rb_level", 32'(level), 5);
    #3;
    reset_n = 1'b0;
    #1;
    check("rb_req_rst", 32'(mem_req), 0);
    check("rb_level_rst", 32'(level), 0);
    check("rb_idle_rst", 32'(idle), 1);
    check("rb_addr_rst", 32'(mem_addr), 0);
    check("rb_data_rst", 32'(mem_data), 0);
    check("rb_flush_rst", 32'(flush_done), 0);
    wq.delete(); wcyc.delete();
    mem_ack = 1'b1;
    tick();
    #2;
    reset_n = 1'b1;
    tick(10);
    check("rb_no_write", 32'(wq.size()), 0);
    check("rb_idle_end", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
